// File: rtl/shift_register_rx_controller.sv
// Receive controller that sequences an external serial-in shift register as the datapath of an async serial line.
// Defining PARITY_CHECK_EN adds an even-parity bit after the data bits; the default build has no parity bit.
module shift_register_rx_controller #(
   parameter int WIDTH        = 6,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic [0:WIDTH-1] sr_q,
   output logic             sr_en,
   output logic             sr_ser,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err,
   output logic             busy,
   output logic [2:0]       dbg_state_o
);
   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam int CYC_W = $clog2(CLKS_PER_BIT);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      SHIFT     = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      HOLD      = 3'd5,
      WAIT_HIGH = 3'd6
   } state_t;

   state_t           state_q;
   logic             sync_q, line_q, line_prev_q;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [BIT_W-1:0] bit_q;
   logic             sr_en_q, sr_ser_q, valid_q, frame_err_q, overrun_q, ovr_seen_q;
   logic [WIDTH-1:0] data_q, sr_word_d;
   logic             tick, line_fall;
`ifdef PARITY_CHECK_EN
   logic             par_q, perr_q, parity_err_q;
`endif

   assign tick      = (cyc_q == CYC_LAST);
   assign cyc_d     = tick ? '0 : cyc_q + CYC_W'(1);
   assign line_fall = line_prev_q & ~line_q;

   // Stage WIDTH-1 holds the first bit shifted in, which becomes the LSB of the word.
   always_comb begin
      sr_word_d = '0;
      for (int i = 0; i < WIDTH; i++) sr_word_d[i] = sr_q[WIDTH-1-i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q       <= 1'b1;
         line_q       <= 1'b1;
         line_prev_q  <= 1'b1;
         state_q      <= IDLE;
         cyc_q        <= '0;
         bit_q        <= '0;
         sr_en_q      <= 1'b0;
         sr_ser_q     <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         ovr_seen_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_q        <= 1'b0;
         perr_q       <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q      <= ser_in;
         line_q      <= sync_q;
         line_prev_q <= line_q;
         cyc_q       <= cyc_d;
         sr_en_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (!line_q) begin
                  state_q <= START;
                  cyc_q   <= '0;
               end
            end
            START: begin
               if (cyc_q == CYC_HALF) begin
                  if (line_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= SHIFT;
                     cyc_q   <= '0;
                     bit_q   <= '0;
`ifdef PARITY_CHECK_EN
                     par_q   <= 1'b0;
                     perr_q  <= 1'b0;
`endif
                  end
               end
            end
            SHIFT: begin
               if (tick) begin
                  sr_en_q  <= 1'b1;
                  sr_ser_q <= line_q;
                  bit_q    <= bit_q + BIT_W'(1);
`ifdef PARITY_CHECK_EN
                  par_q    <= par_q ^ line_q;
                  if (bit_q == BIT_LAST) state_q <= PARITY;
`else
                  if (bit_q == BIT_LAST) state_q <= STOP;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
               if (tick) begin
                  if (par_q ^ line_q) begin
                     parity_err_q <= 1'b1;
                     perr_q       <= 1'b1;
                  end
                  state_q <= STOP;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (!line_q) begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
`ifdef PARITY_CHECK_EN
                  end else if (perr_q) begin
                     state_q     <= IDLE;
`endif
                  end else begin
                     data_q      <= sr_word_d;
                     valid_q     <= 1'b1;
                     ovr_seen_q  <= 1'b0;
                     state_q     <= HOLD;
                  end
               end
            end
            // Handshake: data_valid rises with a stable data_out and holds both until an edge
            // sees data_valid & data_ready; data_ready alone has no effect.
            HOLD: begin
               if (line_fall && !ovr_seen_q) overrun_q <= 1'b1;
               if (data_ready) begin
                  valid_q    <= 1'b0;
                  ovr_seen_q <= 1'b0;
                  state_q    <= (ovr_seen_q || line_fall) ? WAIT_HIGH : IDLE;
               end else if (line_fall) begin
                  ovr_seen_q <= 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (line_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sr_en       = sr_en_q;
   assign sr_ser      = sr_ser_q;
   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;
`ifdef PARITY_CHECK_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_rx_controller.sv
// Directed bench for shift_register_rx_controller with a behavioural model of the external shift register.
// Frame timing follows the default build; PARITY_CHECK_EN shifts the stop sample one bit later.
`timescale 1ns/1ps
module tb_shift_register_rx_controller;
   localparam int W   = 6;
   localparam int CPB = 4;
`ifdef PARITY_CHECK_EN
   localparam int STOP_OFS = 34;
   localparam int NBITS    = W + 2;
`else
   localparam int STOP_OFS = 30;
   localparam int NBITS    = W + 1;
`endif
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HOLD      = 3'd5;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

   logic         clk        = 1'b0;
   logic         rst        = 1'b0;
   logic         ser_in     = 1'b1;
   logic         data_ready = 1'b0;
   logic [0:W-1] sr_q       = '0;
   logic         sr_en, sr_ser, data_valid, frame_err, overrun, parity_err, busy;
   logic [W-1:0] data_out;
   logic [2:0]   dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;

   int           en_cyc_q[$];
   logic         en_bit_q[$];
   int           val_cyc_q[$];
   logic [W-1:0] val_dat_q[$];
   int           ferr_cyc_q[$];
   int           ovr_cyc_q[$];
   int           perr_cyc_q[$];
   logic         valid_prev = 1'b0;

   shift_register_rx_controller #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_in),
      .sr_q        (sr_q),
      .sr_en       (sr_en),
      .sr_ser      (sr_ser),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .parity_err  (parity_err),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // external serial-in shift register: stage 0 takes sr_ser
   always @(posedge clk) if (sr_en) sr_q <= {sr_ser, sr_q[0:W-2]};

   // event recorder, sampled on the falling edge
   always @(negedge clk) begin
      if (sr_en) begin
         en_cyc_q.push_back(cyc_cnt);
         en_bit_q.push_back(sr_ser);
      end
      if (data_valid && !valid_prev) begin
         val_cyc_q.push_back(cyc_cnt);
         val_dat_q.push_back(data_out);
      end
      if (frame_err)  ferr_cyc_q.push_back(cyc_cnt);
      if (overrun)    ovr_cyc_q.push_back(cyc_cnt);
      if (parity_err) perr_cyc_q.push_back(cyc_cnt);
      valid_prev = data_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // driver tasks
   task automatic clear_mon();
      en_cyc_q.delete();
      en_bit_q.delete();
      val_cyc_q.delete();
      val_dat_q.delete();
      ferr_cyc_q.delete();
      ovr_cyc_q.delete();
      perr_cyc_q.delete();
   endtask

   // Start bit then n bits LSB first; t0 is the edge at which the controller first sees the start.
   task automatic send_raw(input logic [15:0] bits, input int n, output int t0);
      @(negedge clk);
      t0 = cyc_cnt + 3;
      ser_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         ser_in = bits[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   // Returns at t0+STOP_OFS+2 with the line still at the stop-bit level.
   task automatic send_frame(input logic [W-1:0] d, input logic stop, output int t0);
      logic [15:0] bits;
      bits = '0;
      bits[W-1:0] = d;
`ifdef PARITY_CHECK_EN
      bits[W]   = ^d;
      bits[W+1] = stop;
`else
      bits[W]   = stop;
`endif
      send_raw(bits, NBITS, t0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ser_in = 1'b1;
      data_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sr_en, sr_ser, data_valid, frame_err, overrun, parity_err, busy} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000000", {sr_en, sr_ser, data_valid, frame_err, overrun, parity_err, busy});
      end
      n_checks++;
      if (data_out !== 6'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
      n_checks++;
      if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      int t0;
      logic [W-1:0] d;
      d = 6'h2D;
      clear_mon();
      data_ready = 1'b1;
      send_frame(d, 1'b1, t0);
      n_checks++;
      if (en_cyc_q.size() != W) begin n_fail++; $display("FAIL basic_en_count: got %0d expected %0d", en_cyc_q.size(), W); end
      for (int k = 0; k < W; k++) begin
         n_checks++;
         if (k >= en_cyc_q.size() || en_cyc_q[k] != t0 + 6 + 4 * k) begin
            n_fail++;
            $display("FAIL basic_en_time[%0d]: got %0d expected %0d", k, (k < en_cyc_q.size()) ? en_cyc_q[k] - t0 : -1, 6 + 4 * k);
         end
         n_checks++;
         if (k >= en_bit_q.size() || en_bit_q[k] !== d[k]) begin
            n_fail++;
            $display("FAIL basic_sr_ser[%0d]: got %b expected %b", k, (k < en_bit_q.size()) ? en_bit_q[k] : 1'bx, d[k]);
         end
      end
      n_checks++;
      if (val_cyc_q.size() != 1 || val_cyc_q[0] != t0 + STOP_OFS) begin
         n_fail++;
         $display("FAIL basic_valid_time: got %0d events, first at %0d expected one at %0d", val_cyc_q.size(), (val_cyc_q.size() > 0) ? val_cyc_q[0] - t0 : -1, STOP_OFS);
      end
      n_checks++;
      if (val_dat_q.size() != 1 || val_dat_q[0] !== 6'h2D) begin
         n_fail++;
         $display("FAIL basic_data: got %h expected 2d", (val_dat_q.size() > 0) ? val_dat_q[0] : 6'hxx);
      end
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b expected 0", data_valid); end
      n_checks++;
      if (ferr_cyc_q.size() + ovr_cyc_q.size() + perr_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL basic_no_errors: got %0d error pulses expected 0", ferr_cyc_q.size() + ovr_cyc_q.size() + perr_cyc_q.size());
      end
   endtask

   task automatic test_hold();
      int t0;
      clear_mon();
      data_ready = 1'b0;
      send_frame(6'h2D, 1'b1, t0);
      for (int c = 0; c < 20; c++) begin
         n_checks++;
         if (data_valid !== 1'b1 || data_out !== 6'h2D) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: got valid=%b data=%h expected valid=1 data=2d", c, data_valid, data_out);
         end
         @(negedge clk);
      end
      data_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 0", data_valid); end
      n_checks++;
      if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL hold_to_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
      clear_mon();
      send_frame(6'h00, 1'b1, t0);
      n_checks++;
      if (val_dat_q.size() != 1 || val_dat_q[0] !== 6'h00 || val_cyc_q[0] != t0 + STOP_OFS) begin
         n_fail++;
         $display("FAIL hold_second_frame: got %0d words first=%h expected one word 00", val_dat_q.size(), (val_dat_q.size() > 0) ? val_dat_q[0] : 6'hxx);
      end
      n_checks++;
      if (en_cyc_q.size() != W) begin n_fail++; $display("FAIL hold_second_en: got %0d expected %0d", en_cyc_q.size(), W); end
   endtask

   task automatic test_glitch();
      clear_mon();
      @(negedge clk);
      ser_in = 1'b0;
      @(negedge clk);
      ser_in = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen: got busy=%b expected 1", busy); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
      repeat (8) @(negedge clk);
      n_checks++;
      if (en_cyc_q.size() + val_cyc_q.size() + ferr_cyc_q.size() + ovr_cyc_q.size() + perr_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL glitch_no_effect: got %0d events expected 0", en_cyc_q.size() + val_cyc_q.size() + ferr_cyc_q.size() + ovr_cyc_q.size() + perr_cyc_q.size());
      end
   endtask

   task automatic test_stop_err();
      int t0;
      clear_mon();
      data_ready = 1'b1;
      send_frame(6'h3F, 1'b0, t0);
      n_checks++;
      if (ferr_cyc_q.size() != 1 || ferr_cyc_q[0] != t0 + STOP_OFS) begin
         n_fail++;
         $display("FAIL stop_frame_err: got %0d pulses first at %0d expected one at %0d", ferr_cyc_q.size(), (ferr_cyc_q.size() > 0) ? ferr_cyc_q[0] - t0 : -1, STOP_OFS);
      end
      n_checks++;
      if (val_cyc_q.size() != 0) begin n_fail++; $display("FAIL stop_no_valid: got %0d valid events expected 0", val_cyc_q.size()); end
      repeat (10) @(negedge clk);
      n_checks++;
      if (dbg_state !== ST_WAIT_HIGH || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_break_hold: got state=%0d busy=%b expected state=%0d busy=1", dbg_state, busy, ST_WAIT_HIGH);
      end
      ser_in = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_recover_idle: got busy=%b expected 0", busy); end
      clear_mon();
      send_frame(6'h0A, 1'b1, t0);
      n_checks++;
      if (val_dat_q.size() != 1 || val_dat_q[0] !== 6'h0A) begin
         n_fail++;
         $display("FAIL stop_next_frame: got %0d words first=%h expected one word 0a", val_dat_q.size(), (val_dat_q.size() > 0) ? val_dat_q[0] : 6'hxx);
      end
   endtask

   task automatic test_overrun();
      int t0;
      int n1;
      clear_mon();
      data_ready = 1'b0;
      send_frame(6'h2D, 1'b1, t0);
      @(negedge clk);
      n1 = cyc_cnt;
      ser_in = 1'b0;
      repeat (4) @(negedge clk);
      ser_in = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (ovr_cyc_q.size() != 1 || ovr_cyc_q[0] != n1 + 3) begin
         n_fail++;
         $display("FAIL overrun_pulse: got %0d pulses first at %0d expected one at %0d", ovr_cyc_q.size(), (ovr_cyc_q.size() > 0) ? ovr_cyc_q[0] - n1 : -1, 3);
      end
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 6'h2D || dbg_state !== ST_HOLD) begin
         n_fail++;
         $display("FAIL overrun_keeps_word: got valid=%b data=%h state=%0d expected valid=1 data=2d state=%0d", data_valid, data_out, dbg_state, ST_HOLD);
      end
      data_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_release: got %b expected 0", data_valid); end
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || data_out !== 6'h2D) begin
         n_fail++;
         $display("FAIL overrun_after: got busy=%b data=%h expected busy=0 data=2d", busy, data_out);
      end
      n_checks++;
      if (en_cyc_q.size() != W || val_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL overrun_dropped: got %0d shifts %0d words expected %0d shifts 1 word", en_cyc_q.size(), val_cyc_q.size(), W);
      end
   endtask

   task automatic test_reset_mid_frame();
      int t0;
      int n0;
      clear_mon();
      data_ready = 1'b1;
      @(negedge clk);
      n0 = cyc_cnt;
      ser_in = 1'b0;
      repeat (4) @(negedge clk);
      ser_in = 1'b1;
      repeat (4) @(negedge clk);
      ser_in = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (cyc_cnt != n0 + 13 || busy !== 1'b1 || sr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_before: got busy=%b sr_en=%b at t0+%0d expected busy=1 sr_en=1 at t0+10", busy, sr_en, cyc_cnt - n0 - 3);
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({sr_en, sr_ser, data_valid, frame_err, overrun, parity_err, busy} !== 7'b0 || data_out !== 6'h00) begin
         n_fail++;
         $display("FAIL midreset_async: got flags=%b data=%h expected flags=0000000 data=00", {sr_en, sr_ser, data_valid, frame_err, overrun, parity_err, busy}, data_out);
      end
      n_checks++;
      if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      repeat (2) @(negedge clk);
      ser_in = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      clear_mon();
      send_frame(6'h15, 1'b1, t0);
      n_checks++;
      if (val_dat_q.size() != 1 || val_dat_q[0] !== 6'h15 || val_cyc_q[0] != t0 + STOP_OFS) begin
         n_fail++;
         $display("FAIL midreset_next_frame: got %0d words first=%h expected one word 15", val_dat_q.size(), (val_dat_q.size() > 0) ? val_dat_q[0] : 6'hxx);
      end
   endtask

`ifdef PARITY_CHECK_EN
   task automatic test_parity();
      int t0;
      clear_mon();
      data_ready = 1'b1;
      // data 07 (three ones) with parity bit 0, stop 1
      send_raw(16'h0087, W + 2, t0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (perr_cyc_q.size() != 1 || perr_cyc_q[0] != t0 + 30) begin
         n_fail++;
         $display("FAIL parity_pulse: got %0d pulses first at %0d expected one at 30", perr_cyc_q.size(), (perr_cyc_q.size() > 0) ? perr_cyc_q[0] - t0 : -1);
      end
      n_checks++;
      if (val_cyc_q.size() != 0 || ferr_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL parity_discard: got %0d words %0d frame errors expected 0 and 0", val_cyc_q.size(), ferr_cyc_q.size());
      end
      n_checks++;
      if (busy !== 1'b0 || en_cyc_q.size() != W) begin
         n_fail++;
         $display("FAIL parity_idle: got busy=%b shifts=%0d expected busy=0 shifts=%0d", busy, en_cyc_q.size(), W);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_glitch();
      test_stop_err();
      test_overrun();
      test_reset_mid_frame();
`ifdef PARITY_CHECK_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_register_rx_controller.md
Name: shift_register_rx_controller

Overview:
- Sequences an external six-bit serial-in shift register (enable/serial-input controlled) as the datapath of an asynchronous serial receiver.
- Detects a start bit on an idle-high serial line, samples each bit at mid-bit, and pulses the register's shift enable once per data bit.
- Checks the stop bit, then presents the assembled word through a valid/ready handshake.
- Sits between the external serial pin and the consumer logic.

Parameters:
WIDTH, 6, data bits per frame; equals the number of shift-register stages.
CLKS_PER_BIT, 4, clk cycles per serial bit; even, at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
ser_in  input  1  serial line; idle high; asynchronous to clk.
sr_q  input  [0:WIDTH-1]  parallel outputs of the external shift register; stage 0 is the serial-input end.
sr_en  output  1  shift enable to the register; one-cycle pulse per data bit.
sr_ser  output  1  serial data to the register's serial input.
data_out  output  [WIDTH-1:0]  received word; bit 0 is the first bit received (LSB first).
data_valid  output  1  word available.
data_ready  input  1  consumer accepts the word.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: start edge seen while in HOLD.
parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature).
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counters=0, all outputs 0, data_out=0. The synchronizer flops reset to 1.
- ser_in passes through a 2-flop synchronizer. "Line" below means the synchronized value.
- t0 is the clk edge at which IDLE first sees line=0.
- IDLE -> START on line=0. The cycle counter clears.
- START: at t0+CLKS_PER_BIT/2, sample the line.
  - Line=0 -> SHIFT, counter cleared.
  - Line=1 (glitch) -> IDLE, no other effect.
- SHIFT: data bit k (k=0..WIDTH-1) is sampled at t0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - At that edge, sr_ser takes the sampled bit and sr_en goes high for exactly one cycle. The register shifts on the following edge.
  - sr_ser holds its value until the next sample.
  - After the WIDTH-th pulse -> STOP.
- STOP: sample at t0+CLKS_PER_BIT/2+(WIDTH+1)*CLKS_PER_BIT.
  - Line=1 -> HOLD. At the same edge: data_out[i] <= sr_q[WIDTH-1-i], data_valid <= 1.
  - Line=0 -> frame_err pulses one cycle, data_out unchanged -> WAIT_HIGH.
- HOLD: data_valid stays high and data_out stays stable until data_valid & data_ready on an edge.
  - On that edge: data_valid <= 0 -> IDLE.
  - data_ready while not valid is ignored.
  - A line falling edge seen in HOLD pulses overrun for one cycle. That frame is dropped, and the controller does not re-arm until line=1 after leaving HOLD.
- WAIT_HIGH: remain until line=1 -> IDLE. A break holds here.
- sr_en is never asserted outside SHIFT. A frame aborted by reset leaves partial register contents, which are overwritten by the next full frame.
- Counters: the bit counter uses clog2(WIDTH+1) bits; the cycle counter uses clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - An even-parity bit follows the data bits. It is sampled one bit period after the last data bit, and the stop sample moves one bit period later.
  - Parity is the XOR of the sampled data bits and the parity bit. A nonzero result pulses parity_err for one cycle at the parity sample edge.
  - On a parity error the frame is discarded: no data_valid; the controller still checks the stop bit, then returns to IDLE (stop=1) or WAIT_HIGH (stop=0, frame_err also pulses).
  - sr_en is not pulsed for the parity bit.
- Not defined: parity_err is tied 0 and the frame contains no parity bit.

Test Plan:
1. Reset mid-frame: drop rst at t0+10 during a frame -> all outputs 0 immediately (asynchronous), state IDLE. A following clean frame of 0x15 is received correctly.
2. WIDTH=6, CLKS_PER_BIT=4, frame start, 6'h2D LSB first (1,0,1,1,0,1), stop=1, data_ready=1 -> exactly 6 sr_en pulses at t0+6, 10, ..., 26 with sr_ser=1,0,1,1,0,1. data_valid high at t0+30 for one cycle, data_out=6'h2D.
3. data_ready=0 for 20 cycles after valid -> data_valid and data_out=6'h2D hold. Raise ready -> valid drops next edge. A second frame 6'h00 is then received correctly.
4. Start glitch: line low for 1 cycle only -> no sr_en, busy returns low by t0+3, no error flags.
5. Stop bit 0 on frame 6'h3F -> frame_err pulse at t0+30, no data_valid. Line held low 10 more cycles stays in WAIT_HIGH. Next frame 6'h0A is received normally.
6. Start edge while in HOLD -> one-cycle overrun pulse, data_out keeps the old word. With PARITY_CHECK_EN, 6'h07 plus parity bit 0 -> parity_err pulse at t0+30, no data_valid.
